// File: rtl/cdc_pkg.sv
// Shared clock-domain-crossing helpers: Gray/binary conversion and the FIFO pointer type.
package cdc_pkg;

  localparam int PTR_WIDTH = 5;
  localparam int MAX_WIDTH = 32;

  // Pointer type for the default 16-deep FIFO (ADDR_WIDTH = 4, one extra wrap bit).
  typedef logic [PTR_WIDTH-1:0] ptr_t;
  typedef logic [MAX_WIDTH-1:0] wide_t;

  // Converters work on zero-extended values; callers narrow the result with a size cast.
  function automatic wide_t bin2gray(input wide_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic wide_t gray2bin(input wide_t gray);
    wide_t bin;
    bin = gray;
    for (int i = 1; i < MAX_WIDTH; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_gray2bin.sv
// Width-parameterised Gray-to-binary converter used for the synchronized read pointer.
module gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(cdc_pkg::gray2bin(cdc_pkg::wide_t'(gray)));

endmodule

// File: rtl/fifo_wptr_full.sv
// Async FIFO write-side pointer and full flag, all in the clk_i domain.
// Optional almost-full / fill-level outputs are built when FIFO_ALMOST_FULL_EN is defined.
module fifo_wptr_full
  import cdc_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  winc_i,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync_i,
  output logic                  wen_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [ADDR_WIDTH:0]   wptr_gray_o,
  output logic                  full_o,
  output logic                  overflow_o
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   fill_level_o
`endif
);

  localparam int PW  = ADDR_WIDTH + 1;
  localparam int MSB = ADDR_WIDTH;

  logic [MSB:0] wbin_q;
  logic [MSB:0] wbin_next;
  logic [MSB:0] gray_next;
  logic [MSB:0] rptr_full_cmp;
  logic         full_next;

  // Gating with rst_ni keeps the RAM strobe low while reset is held.
  assign wen_o     = winc_i & ~full_o & rst_ni;
  assign waddr_o   = wbin_q[ADDR_WIDTH-1:0];
  assign wbin_next = wbin_q + {{ADDR_WIDTH{1'b0}}, wen_o};
  assign gray_next = PW'(bin2gray(wide_t'(wbin_next)));

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign rptr_full_cmp = {~rptr_gray_sync_i[MSB:MSB-1], rptr_gray_sync_i[MSB-2:0]};
  assign full_next     = (gray_next == rptr_full_cmp);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wbin_q      <= '0;
      wptr_gray_o <= '0;
      full_o      <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      wbin_q      <= wbin_next;
      wptr_gray_o <= gray_next;
      full_o      <= full_next;
      overflow_o  <= winc_i & full_o;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [MSB:0] AFULL_LEVEL = PW'((2 ** ADDR_WIDTH) - AFULL_THRESH);

  logic [MSB:0] rbin;
  logic [MSB:0] fill_level_next;

  gray2bin #(
    .WIDTH(PW)
  ) u_rptr_gray2bin (
    .gray(rptr_gray_sync_i),
    .bin (rbin)
  );

  assign fill_level_next = wbin_next - rbin;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_level_o  <= '0;
      almost_full_o <= 1'b0;
    end else begin
      fill_level_o  <= fill_level_next;
      almost_full_o <= (fill_level_next >= AFULL_LEVEL);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full (ADDR_WIDTH=4, AFULL_THRESH=2).
module tb_fifo_wptr_full;
  import cdc_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          winc;
  ptr_t          rptr_gray;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr_gray;
  logic          full;
  logic          overflow;
`ifdef FIFO_ALMOST_FULL_EN
  logic          almost_full;
  logic [AW:0]   fill_level;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   wbin_m;
  int   rbin_m;
  logic full_m;
  int   accepted;
  logic acc;

  fifo_wptr_full #(
    .ADDR_WIDTH  (AW),
    .AFULL_THRESH(2)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .winc_i          (winc),
    .rptr_gray_sync_i(rptr_gray),
    .wen_o           (wen),
    .waddr_o         (waddr),
    .wptr_gray_o     (wptr_gray),
    .full_o          (full),
    .overflow_o      (overflow)
`ifdef FIFO_ALMOST_FULL_EN
    ,
    .almost_full_o   (almost_full),
    .fill_level_o    (fill_level)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [AW:0] to_gray(input int b);
    logic [AW:0] v;
    v = (AW + 1)'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic reset_model();
    wbin_m = 0;
    rbin_m = 0;
    full_m = 1'b0;
  endtask

  // One clock of stimulus: drive write request and read pointer, check comb then registered outputs.
  task automatic apply_stimulus(input logic w, input int rb, input string tag, output logic accepted_wr);
    logic        wen_exp;
    logic        old_full;
    logic [AW:0] prev_gray;
    winc      = w;
    rptr_gray = to_gray(rb);
    #1;
    old_full  = full_m;
    wen_exp   = w & ~full_m;
    prev_gray = wptr_gray;
    check_output({tag, "_wen"}, 32'(wen), 32'(wen_exp));
    check_output({tag, "_waddr"}, 32'(waddr), 32'(wbin_m % DEPTH));
    @(posedge clk);
    #1;
    if (wen_exp) wbin_m = (wbin_m + 1) % 32;
    rbin_m = rb;
    full_m = (((wbin_m - rbin_m) + 32) % 32) == DEPTH;
    check_output({tag, "_full"}, 32'(full), 32'(full_m));
    check_output({tag, "_gray"}, 32'(wptr_gray), 32'(to_gray(wbin_m)));
    check_output({tag, "_overflow"}, 32'(overflow), 32'(w & old_full));
    check_output({tag, "_hamming"}, 32'($countones(prev_gray ^ wptr_gray)), wen_exp ? 32'd1 : 32'd0);
    accepted_wr = wen_exp;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_wen"}, 32'(wen), 32'd0);
    check_output({tag, "_waddr"}, 32'(waddr), 32'd0);
    check_output({tag, "_gray"}, 32'(wptr_gray), 32'd0);
    check_output({tag, "_full"}, 32'(full), 32'd0);
    check_output({tag, "_overflow"}, 32'(overflow), 32'd0);
`ifdef FIFO_ALMOST_FULL_EN
    check_output({tag, "_afull"}, 32'(almost_full), 32'd0);
    check_output({tag, "_fill"}, 32'(fill_level), 32'd0);
`endif
  endtask

  initial begin
    rst_n     = 1'b1;
    winc      = 1'b1;
    rptr_gray = '0;
    #1 rst_n  = 1'b0;
    #1;
    check_all_zero("reset");
    reset_model();

    // Release between edges; the very next edge must already accept a write.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 0, "fill", acc);
    check_output("fill_gray_end", 32'(wptr_gray), 32'(5'b11000));
    check_output("fill_full_end", 32'(full), 32'd1);

    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 0, "ovf", acc);
    check_output("ovf_gray_held", 32'(wptr_gray), 32'(5'b11000));
    apply_stimulus(1'b0, 0, "ovf_end", acc);

    apply_stimulus(1'b0, 1, "rd_adv", acc);
    check_output("rd_adv_full", 32'(full), 32'd0);
    apply_stimulus(1'b1, 1, "rd_wr", acc);

    // Interleaved traffic past the pointer wrap, reads never overtaking writes.
    accepted = 0;
    for (int i = 0; i < 300 && accepted < 40; i++) begin
      int rb;
      rb = rbin_m;
      if ((i % 2 == 0) && (rbin_m != wbin_m)) rb = (rbin_m + 1) % 32;
      apply_stimulus(i % 3 != 2, rb, "mix", acc);
      if (acc) accepted++;
    end
    check_output("mix_accepted", 32'(accepted), 32'd40);

    // Asynchronous reset in the middle of a burst at wbin = 7.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    reset_model();
    for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 0, "burst", acc);
    check_output("burst_gray7", 32'(wptr_gray), 32'(5'b00100));
    winc = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    rst_n = 1'b1;
    winc  = 1'b0;
    reset_model();
    @(posedge clk);
    #1;

    // Filling write and read advance on the same edge must not flag full.
    for (int i = 0; i < 15; i++) apply_stimulus(1'b1, 0, "pre_same", acc);
    apply_stimulus(1'b1, 1, "same_cycle", acc);
    check_output("same_cycle_full", 32'(full), 32'd0);

`ifdef FIFO_ALMOST_FULL_EN
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    reset_model();
    for (int i = 0; i < 13; i++) apply_stimulus(1'b1, 0, "afull_fill", acc);
    check_output("fill_13", 32'(fill_level), 32'd13);
    check_output("afull_13", 32'(almost_full), 32'd0);
    apply_stimulus(1'b1, 0, "afull_fill", acc);
    check_output("fill_14", 32'(fill_level), 32'd14);
    check_output("afull_14", 32'(almost_full), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
